// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: shared prescaler driving NUM_CH independent countdown
// channels. Each channel is periodic or one-shot, raises a sticky pending
// flag plus a one-cycle expiry pulse, and irq is the OR of all pending flags.
module tick_timer_ctrl #(
    parameter int CLK_DIV = 100_000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] start_req,
    input  logic [NUM_CH-1:0] stop_req,
    input  logic [NUM_CH-1:0] ack,
    output logic              base_tick,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] expire_pulse,
    output logic              irq
);

    localparam int              PRE_W   = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    logic [PRE_W-1:0] pre_cnt_reg;
    logic             base_tick_reg;

    // Free-running prescaler; the tick is registered so it lands the cycle
    // after the counter reaches its terminal value.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pre_cnt_reg   <= '0;
            base_tick_reg <= 1'b0;
        end else if (pre_cnt_reg == PRE_MAX) begin
            pre_cnt_reg   <= '0;
            base_tick_reg <= 1'b1;
        end else begin
            pre_cnt_reg   <= pre_cnt_reg + PRE_W'(1);
            base_tick_reg <= 1'b0;
        end
    end

    assign base_tick = base_tick_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [2:0] CH_IDX = 3'(gi);

            ch_state_t        state_reg, state_next;
            logic [CNT_W-1:0] period_reg;
            logic             mode_reg;
            logic [CNT_W-1:0] count_reg, count_next;
            logic             pend_reg, pend_next;
            logic             pulse_reg, pulse_next;
            logic             expire_set;
            logic             cfg_hit;

            // Indices outside 0..NUM_CH-1 never match any channel, so such
            // writes fall on the floor.
            assign cfg_hit = cfg_we && (cfg_ch == CH_IDX);

            // Configuration registers; a running count is not touched here,
            // the new period is picked up at the next start or reload.
            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) begin
                    period_reg <= '0;
                    mode_reg   <= 1'b0;
                end else if (cfg_hit) begin
                    period_reg <= cfg_period;
                    mode_reg   <= cfg_mode;
                end
            end

            // Next-state logic with priority stop > start > tick/expiry.
            // A tick coinciding with a start is swallowed by the start branch.
            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                pulse_next = 1'b0;
                expire_set = 1'b0;
                if (stop_req[gi]) begin
                    state_next = ST_IDLE;
                    count_next = CNT_ZERO;
                end else if (start_req[gi]) begin
                    if (period_reg != CNT_ZERO) begin
                        state_next = ST_RUN;
                        count_next = period_reg;
                    end
                end else if ((state_reg == ST_RUN) && base_tick_reg) begin
                    if (count_reg == CNT_ONE) begin
                        pulse_next = 1'b1;
                        expire_set = 1'b1;
                        if (mode_reg || (period_reg == CNT_ZERO)) begin
                            state_next = ST_IDLE;
                            count_next = CNT_ZERO;
                        end else begin
                            count_next = period_reg;
                        end
                    end else begin
                        count_next = count_reg - CNT_ONE;
                    end
                end
                // A fresh expiry beats a simultaneous acknowledge.
                if (expire_set) begin
                    pend_next = 1'b1;
                end else if (ack[gi]) begin
                    pend_next = 1'b0;
                end else begin
                    pend_next = pend_reg;
                end
            end

            // Channel state, count, pending and pulse registers.
            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                    pend_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                    pend_reg  <= pend_next;
                    pulse_reg <= pulse_next;
                end
            end

            assign running[gi]      = (state_reg == ST_RUN);
            assign pending[gi]      = pend_reg;
            assign expire_pulse[gi] = pulse_reg;
        end
    endgenerate

    assign irq = |pending;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl with CLK_DIV=10, NUM_CH=4.
// Edge k is the k-th rising edge after reset release; base_tick is visible
// after edges 10,20,... and a tick is consumed by the channels at edge 10m+1.
module tb_tick_timer_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_mode;
    logic [3:0]  start_req;
    logic [3:0]  stop_req;
    logic [3:0]  ack;
    logic        base_tick;
    logic [3:0]  running;
    logic [3:0]  pending;
    logic [3:0]  expire_pulse;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;
    exp_t exp_q[$];

    tick_timer_ctrl #(
        .CLK_DIV(10),
        .NUM_CH (4),
        .CNT_W  (16)
    ) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_mode    (cfg_mode),
        .start_req   (start_req),
        .stop_req    (stop_req),
        .ack         (ack),
        .base_tick   (base_tick),
        .running     (running),
        .pending     (pending),
        .expire_pulse(expire_pulse),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Monitor: prescaler tick every cycle, expiry pulses against the queue.
    always @(negedge clk) begin
        check("base_tick", 32'(base_tick), 32'((cyc != 0) && (cyc % 10 == 0)));
        if (expire_pulse != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(expire_pulse), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("pulse cyc=%0d vec=%b expected cyc=%0d vec=%b", cyc, expire_pulse, e.cyc, e.vec);
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_vec", 32'(expire_pulse), 32'(e.vec));
            end
        end
    end

    task automatic at_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic cfg_at(input int k, input logic [2:0] ch, input logic [15:0] per, input logic md);
        at_cyc(k - 1);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_mode = md;
        @(negedge clk);
        cfg_we = 1'b0;
        $display("cfg edge=%0d ch=%0d period=%0d mode=%0d", k, ch, per, md);
    endtask

    task automatic start_at(input int k, input logic [3:0] m);
        at_cyc(k - 1);
        start_req = m;
        @(negedge clk);
        start_req = 4'b0000;
        $display("start edge=%0d mask=%b", k, m);
    endtask

    task automatic stop_at(input int k, input logic [3:0] m);
        at_cyc(k - 1);
        stop_req = m;
        @(negedge clk);
        stop_req = 4'b0000;
        $display("stop edge=%0d mask=%b", k, m);
    endtask

    task automatic ack_at(input int k, input logic [3:0] m);
        at_cyc(k - 1);
        ack = m;
        @(negedge clk);
        ack = 4'b0000;
        $display("ack edge=%0d mask=%b", k, m);
    endtask

    task automatic status(input string name, input int k, input logic [3:0] run_e, input logic [3:0] pend_e);
        at_cyc(k);
        $display("status %s cyc=%0d running=%b pending=%b irq=%b", name, cyc, running, pending, irq);
        check({name, "_running"}, 32'(running), 32'(run_e));
        check({name, "_pending"}, 32'(pending), 32'(pend_e));
        check({name, "_irq"}, 32'(irq), 32'(|pend_e));
    endtask

    function automatic void push_exp(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_period = 16'd0; cfg_mode = 1'b0;
        start_req = 4'b0; stop_req = 4'b0; ack = 4'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        status("reset_state", 1, 4'b0000, 4'b0000);

        // Periodic ch0 (period 3) and one-shot ch1 (period 2).
        cfg_at(2, 3'd0, 16'd3, 1'b0);
        cfg_at(3, 3'd1, 16'd2, 1'b1);
        start_at(5, 4'b0001);
        start_at(7, 4'b0010);
        push_exp(21, 4'b0010);
        push_exp(31, 4'b0001);
        push_exp(61, 4'b0001);

        status("oneshot_done", 22, 4'b0001, 4'b0010);
        ack_at(25, 4'b0010);
        status("ch1_acked", 26, 4'b0001, 4'b0000);
        status("periodic_first", 32, 4'b0001, 4'b0001);
        ack_at(35, 4'b0001);
        status("ch0_acked", 36, 4'b0001, 4'b0000);

        // Ack in the expiry cycle: set wins.
        ack_at(61, 4'b0001);
        status("ack_vs_set", 62, 4'b0001, 4'b0001);
        ack_at(65, 4'b0001);
        status("ch0_acked2", 66, 4'b0001, 4'b0000);

        // Stop in the expiry cycle: no pulse, no pending.
        stop_at(91, 4'b0001);
        status("stop_vs_expiry", 92, 4'b0000, 4'b0000);

        // ch2 periodic 2; ch3 start with period 0 is ignored.
        cfg_at(100, 3'd2, 16'd2, 1'b0);
        start_at(105, 4'b0100);
        start_at(110, 4'b1000);
        status("start_period0", 111, 4'b0100, 4'b0000);
        cfg_at(112, 3'd3, 16'd5, 1'b0);
        start_at(115, 4'b1000);
        push_exp(141, 4'b0100);
        push_exp(161, 4'b1100);
        push_exp(181, 4'b1100);
        status("both_running", 116, 4'b1100, 4'b0000);

        // Retrigger ch2 in its expiry cycle; shrink ch3 period while count=4.
        start_at(121, 4'b0100);
        status("start_vs_expiry", 122, 4'b1100, 4'b0000);
        cfg_at(125, 3'd3, 16'd2, 1'b0);
        cfg_at(130, 3'd7, 16'd1, 1'b1);
        status("ch2_pend", 142, 4'b1100, 4'b0100);
        status("both_pend", 162, 4'b1100, 4'b1100);

        // Asynchronous reset mid-operation.
        at_cyc(185);
        #2 reset = 1'b1;
        #1;
        $display("async reset applied running=%b pending=%b pulse=%b irq=%b tick=%b",
                 running, pending, expire_pulse, irq, base_tick);
        check("rst_running", 32'(running), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_pulse", 32'(expire_pulse), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tick", 32'(base_tick), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        status("post_reset", 5, 4'b0000, 4'b0000);
        // Periods were cleared by reset, so these starts are ignored.
        start_at(20, 4'b1111);
        status("post_reset_start", 21, 4'b0000, 4'b0000);
        at_cyc(45);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
